mac_operand_feeder: RTL and testbench
=====================================

Name: mac_operand_feeder

Overview:
- Upstream producer for the 144-input MAC adder tree.
- Accepts activation/weight operand beats over a valid/ready handshake, LANES pairs per beat.
- Multiplies each pair as signed 8b x 8b into a 16b product and packs the products into a 2304-bit product vector.
- Issues the vector with a one-cycle valid strobe. The tree has no backpressure and samples the vector on the strobe edge.

Parameters:
- LANES, 16, operand pairs per beat; must divide 144.
- BEATS, 144/LANES (9), beats per frame; derived, not overridable.
- NPROD, 144, products per frame; fixed by the adder tree.

Ports:
- clk      in   1     clock.
- rstn     in   1     asynchronous active-low reset.
- in_vld   in   1     operand beat valid.
- in_rdy   out  1     feeder can accept a beat.
- in_act   in   8*LANES  signed activations, lane l at [8l+7:8l].
- in_wgt   in   8*LANES  signed weights, lane l at [8l+7:8l].
- in_last  in   1     final beat of frame; qualified by in_vld && in_rdy.
- out_vld  out  1     one-cycle strobe; product vector complete.
- dout     out  2304  products; product p at [16p+15:16p].
- short_o  out  1     frame was closed early by in_last (sticky until next issue).

Behaviour:
- Reset values: in_rdy=0 while rstn low, then 1 from the first clk edge after release. out_vld=0, dout=0, short_o=0, beat counter=0, state=FILL.
- Accept: a beat is accepted when in_vld && in_rdy at a rising edge.
- Product placement: product p = beat*LANES + l, computed as $signed(act_l)*$signed(wgt_l) and written as full 16b (-128*-128 = 16384 fits).
- Write timing: products are written into the buffer slot for the current beat at the accepting edge.
- States:
  - FILL: in_rdy=1. Each accepted beat writes its slot and increments the counter. On acceptance with counter==BEATS-1 or in_last=1, go to ISSUE.
  - ISSUE (exactly one cycle): out_vld=1, in_rdy=0, dout stable. Next cycle returns to FILL with counter=0.
- Latency: out_vld rises the cycle after the closing beat is accepted. Maximum throughput is one frame per BEATS+1 cycles.
- Early close: in_last on beat k<BEATS-1 zeroes slots k+1..BEATS-1 at the same edge and sets short_o. Zeroed slots contribute nothing to the tree sum.
- in_last on beat BEATS-1: normal close, short_o=0.
- Full frame without in_last: issued normally at BEATS beats; in_last is not required.
- short_o: updated at the closing edge, held through ISSUE, cleared at the next frame close.
- in_vld during ISSUE: ignored (in_rdy=0). Upstream must hold the beat.
- dout between strobes: reflects the partially filled buffer. It is only meaningful while out_vld=1.
- Reset mid-frame: everything returns to reset values, the partial frame is discarded and no strobe is issued.

Optional Feature:
- Macro: MAC_OPERAND_FEEDER_PIPE_EN.
- Enabled:
  - Operands and in_last are registered in an input stage before the multiply.
  - The slot is written one edge after acceptance, so out_vld rises two cycles after the closing beat.
  - in_rdy also drops in the cycle the staged closing beat is being written. No beat is accepted between close and ISSUE end.
  - Throughput is one frame per BEATS+2 cycles.
- Disabled: behaviour exactly as above.

Decomposition:
- Shared package mac_pkg:
  - Constants: NPROD=144, OPW=8, PRODW=16, DOUT_W=NPROD*PRODW.
  - State typedef: FILL/ISSUE.
  - The adder tree's level widths also belong in this package.
- Sub-module mac_lane_mul: one signed 8x8 multiplier. It has an optional register stage under the macro and is instantiated LANES times by generate.

Test Plan:
- Full frame: 9 beats, all act=3, wgt=-2, no in_last -> out_vld one cycle after beat 9, every product 16'hFFFA, short_o=0.
- Back-to-back: in_vld held high for two frames -> in_rdy=0 only during each ISSUE cycle, 2 strobes 10 cycles apart, second frame's values correct, first dout unchanged during its strobe.
- Early close: 4 beats act=127, wgt=127, in_last on beat 4 -> products 0..63 = 16'h3F01, products 64..143 = 0, short_o=1, then the next full frame clears short_o.
- Corner products: lane pairs (-128,-128), (-128,127), (0,x) -> 16'h4000, 16'hC080, 16'h0000 at the correct bit positions.
- Handshake gaps: in_vld toggled randomly with an identical operand sequence -> same dout as the gap-free run; strobe only after the 9th accepted beat.
- Reset: assert rstn low after beat 5 -> out_vld, dout and short_o = 0. After release, a new 9-beat frame issues correctly with no spurious strobe.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC operand feeder and the 144-input adder tree.
// Optional input pipeline stage is selected with MAC_OPERAND_FEEDER_PIPE_EN.
package mac_pkg;
    localparam int NPROD       = 144;
    localparam int OPW         = 8;
    localparam int PRODW       = 16;
    localparam int DOUT_W      = NPROD * PRODW;
    localparam int TREE_LEVELS = $clog2(NPROD);
    localparam int TREE_SUM_W  = PRODW + TREE_LEVELS;

    // Each adder-tree level grows the partial sum by one bit over its children.
    function automatic int tree_level_w(input int lvl);
        return PRODW + lvl;
    endfunction

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_t;
endpackage

// File: rtl/mac_operand_feeder_if.sv
// Operand-beat and product-vector bundle between producer, feeder and adder tree.
// Handshake: a beat transfers on a rising edge where in_vld && in_rdy; the producer
// holds in_act/in_wgt/in_last stable while in_vld=1 and in_rdy=0. out_vld is a
// one-cycle strobe with no backpressure; dout is meaningful only while out_vld=1.
interface mac_operand_feeder_if
    import mac_pkg::*;
#(
    parameter int LANES = 16
) ();
    logic                 in_vld;
    logic                 in_rdy;
    logic [OPW*LANES-1:0] in_act;
    logic [OPW*LANES-1:0] in_wgt;
    logic                 in_last;
    logic                 out_vld;
    logic [DOUT_W-1:0]    dout;
    logic                 short_o;
    state_t               dbg_state;

    modport master (
        output in_vld, in_act, in_wgt, in_last,
        input  in_rdy, out_vld, dout, short_o, dbg_state
    );

    modport slave (
        input  in_vld, in_act, in_wgt, in_last,
        output in_rdy, out_vld, dout, short_o, dbg_state
    );
endinterface

// File: rtl/mac_lane_mul.sv
// One signed 8x8 -> 16 multiplier lane; with MAC_OPERAND_FEEDER_PIPE_EN the operands
// are registered on i_en before the multiply.
module mac_lane_mul
    import mac_pkg::*;
(
`ifdef MAC_OPERAND_FEEDER_PIPE_EN
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_en,
`endif
    input  logic signed [OPW-1:0]   i_act,
    input  logic signed [OPW-1:0]   i_wgt,
    output logic signed [PRODW-1:0] o_prod
);
`ifdef MAC_OPERAND_FEEDER_PIPE_EN
    logic signed [OPW-1:0] r_act;
    logic signed [OPW-1:0] r_wgt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_act <= '0;
            r_wgt <= '0;
        end else if (i_en) begin
            r_act <= i_act;
            r_wgt <= i_wgt;
        end
    end

    assign o_prod = PRODW'(r_act) * PRODW'(r_wgt);
`else
    // Sign-extend first so the low 16 bits hold the exact product (-128*-128 fits).
    assign o_prod = PRODW'(i_act) * PRODW'(i_wgt);
`endif
endmodule

// File: rtl/mac_operand_feeder.sv
// Collects LANES operand pairs per beat, multiplies them and issues the 144-product
// vector to the adder tree with a one-cycle strobe. Pipe stage: MAC_OPERAND_FEEDER_PIPE_EN.
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int LANES = 16
) (
    input logic                 clk,
    input logic                 rstn,
    mac_operand_feeder_if.slave bus
);
    localparam int BEATS  = NPROD / LANES;
    localparam int SLOT_W = LANES * PRODW;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_alive;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_short;
    logic [DOUT_W-1:0]   r_buf;
    logic                w_rdy;
    logic                w_vld;
    logic                w_acc;
    logic                w_acc_close;
    logic                w_stall;
    logic [SLOT_W-1:0]   w_prod;
    logic                w_wr_en;
    logic [CNT_W-1:0]    w_wr_slot;
    logic                w_wr_close;
    logic                w_wr_short;

    assign w_acc       = bus.in_vld && w_rdy;
    assign w_acc_close = w_acc && ((r_cnt == LAST_BEAT) || bus.in_last);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane_mul u_mul (
`ifdef MAC_OPERAND_FEEDER_PIPE_EN
            .clk    (clk),
            .rstn   (rstn),
            .i_en   (w_acc),
`endif
            .i_act  (bus.in_act[OPW*l +: OPW]),
            .i_wgt  (bus.in_wgt[OPW*l +: OPW]),
            .o_prod (w_prod[PRODW*l +: PRODW])
        );
    end

`ifdef MAC_OPERAND_FEEDER_PIPE_EN
    logic             r_stg_vld;
    logic             r_stg_close;
    logic             r_stg_short;
    logic [CNT_W-1:0] r_stg_slot;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stg_vld   <= 1'b0;
            r_stg_close <= 1'b0;
            r_stg_short <= 1'b0;
            r_stg_slot  <= '0;
        end else begin
            r_stg_vld <= w_acc;
            if (w_acc) begin
                r_stg_slot  <= r_cnt;
                r_stg_close <= w_acc_close;
                r_stg_short <= bus.in_last && (r_cnt != LAST_BEAT);
            end
        end
    end

    assign w_wr_en    = r_stg_vld;
    assign w_wr_slot  = r_stg_slot;
    assign w_wr_close = r_stg_close;
    assign w_wr_short = r_stg_short;
    // Hold off upstream while the staged closing beat lands, so nothing slips in before ISSUE.
    assign w_stall    = r_stg_vld && r_stg_close;
`else
    assign w_wr_en    = w_acc;
    assign w_wr_slot  = r_cnt;
    assign w_wr_close = w_acc_close;
    assign w_wr_short = bus.in_last && (r_cnt != LAST_BEAT);
    assign w_stall    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= FILL;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:    if (w_wr_en && w_wr_close) w_next = ISSUE;
            ISSUE:   w_next = FILL;
            default: w_next = FILL;
        endcase
    end

    always_comb begin
        w_rdy = r_alive && (r_state == FILL) && !w_stall;
        w_vld = (r_state == ISSUE);
    end

    // in_rdy stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_alive <= 1'b0;
        else       r_alive <= 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_acc) begin
            r_cnt <= w_acc_close ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf   <= '0;
            r_short <= 1'b0;
        end else if (w_wr_en) begin
            for (int s = 0; s < BEATS; s++) begin
                if (CNT_W'(s) == w_wr_slot)
                    r_buf[s*SLOT_W +: SLOT_W] <= w_prod;
                else if (w_wr_short && (CNT_W'(s) > w_wr_slot))
                    r_buf[s*SLOT_W +: SLOT_W] <= '0;
            end
            if (w_wr_close) r_short <= w_wr_short;
        end
    end

    assign bus.in_rdy    = w_rdy;
    assign bus.out_vld   = w_vld;
    assign bus.dout      = r_buf;
    assign bus.short_o   = r_short;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: directed frames, a frame-level reference model checked
// every cycle, and literal product expectations for the listed corner cases.
module tb_mac_operand_feeder;
    import mac_pkg::*;

    localparam int LANES = 16;
    localparam int BEATS = NPROD / LANES;
    localparam int BW    = OPW * LANES;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_operand_feeder_if #(.LANES(LANES)) bus ();

    mac_operand_feeder #(.LANES(LANES)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [DOUT_W-1:0] act,
                             input logic [DOUT_W-1:0] exp);
        int first;
        first = -1;
        total++;
        for (int p = 0; p < NPROD; p++)
            if (first < 0 && act[16*p +: 16] !== exp[16*p +: 16]) first = p;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s: product %0d got %h expected %h (t=%0t)", name, first,
                     act[16*first +: 16], exp[16*first +: 16], $time);
        end
    endtask

    // Reference model: accepted beats of the open frame, and what the next cycle must show.
    logic [BW-1:0]     q_act[$];
    logic [BW-1:0]     q_wgt[$];
    bit                m_alive = 1'b0;
    bit                m_issue = 1'b0;
    bit                m_short = 1'b0;
    logic [DOUT_W-1:0] m_vec   = '0;
    int                last_acc_cyc = 0;
    int                strobe_cnt = 0;
    int                last_strobe_cyc = 0;
    int                prev_strobe_cyc = 0;
    logic [DOUT_W-1:0] last_dout = '0;
    logic              last_short = 1'b0;

    function automatic logic [DOUT_W-1:0] build_frame();
        logic [DOUT_W-1:0] v;
        logic signed [7:0]  a;
        logic signed [7:0]  w;
        logic signed [15:0] pr;
        v = '0;
        for (int b = 0; b < q_act.size(); b++)
            for (int l = 0; l < LANES; l++) begin
                a  = q_act[b][8*l +: 8];
                w  = q_wgt[b][8*l +: 8];
                pr = 16'(a) * 16'(w);
                v[16*(b*LANES + l) +: 16] = pr;
            end
        return v;
    endfunction

    always @(negedge clk) begin : cmp
        bit accept;
        if (!rstn) begin
            q_act.delete();
            q_wgt.delete();
            m_alive = 1'b0;
            m_issue = 1'b0;
            m_short = 1'b0;
            check("rst_out_vld", bus.out_vld, 32'd0);
            check("rst_in_rdy", bus.in_rdy, 32'd0);
            check("rst_short_o", bus.short_o, 32'd0);
            check_vec("rst_dout", bus.dout, '0);
        end else begin
            check("out_vld", bus.out_vld, m_issue);
            check("in_rdy", bus.in_rdy, m_alive && !m_issue);
            check("short_o", bus.short_o, m_short);
            check("state", bus.dbg_state, m_issue ? ISSUE : FILL);
            if (m_issue) check_vec("dout", bus.dout, m_vec);
            if (bus.out_vld) begin
                strobe_cnt++;
                prev_strobe_cyc = last_strobe_cyc;
                last_strobe_cyc = cyc;
                last_dout       = bus.dout;
                last_short      = bus.short_o;
            end
            accept  = bus.in_vld && m_alive && !m_issue;
            m_issue = 1'b0;
            m_alive = 1'b1;
            if (accept) begin
                q_act.push_back(bus.in_act);
                q_wgt.push_back(bus.in_wgt);
                last_acc_cyc = cyc;
                if (q_act.size() == BEATS || bus.in_last) begin
                    m_vec   = build_frame();
                    m_short = bus.in_last && (q_act.size() < BEATS);
                    m_issue = 1'b1;
                    q_act.delete();
                    q_wgt.delete();
                end
            end
        end
    end

    function automatic logic [BW-1:0] splat(input logic [7:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [BW-1:0] pat_vec(input int seed, input int b);
        logic [BW-1:0] v;
        for (int l = 0; l < LANES; l++) v[8*l +: 8] = 8'((seed*37 + b*13 + l*29) % 256);
        return v;
    endfunction

    // Called at posedge+2; returns at posedge+2 just after the beat was accepted.
    task automatic drive(input logic [BW-1:0] a, input logic [BW-1:0] w, input logic last);
        int n;
        n = 0;
        bus.in_vld  = 1'b1;
        bus.in_act  = a;
        bus.in_wgt  = w;
        bus.in_last = last;
        forever begin
            @(negedge clk);
            if (bus.in_rdy) break;
            n++;
            if (n > 40) begin
                total++;
                bad++;
                $display("FAIL drive_timeout: in_rdy got 0 expected 1 within 40 cycles");
                break;
            end
        end
        @(posedge clk);
        #2;
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_vld = 1'b0;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #2;
        end
    endtask

    task automatic frame_pat(input int sa, input int sw, input int gap_max);
        for (int b = 0; b < BEATS; b++) begin
            drive(pat_vec(sa, b), pat_vec(sw, b), 1'b0);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int sc;
        logic [BW-1:0] a;
        logic [BW-1:0] w;
        bus.in_vld  = 1'b0;
        bus.in_act  = '0;
        bus.in_wgt  = '0;
        bus.in_last = 1'b0;
        rstn        = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_out_vld", bus.out_vld, 32'd0);
        check("reset_in_rdy", bus.in_rdy, 32'd0);
        check("reset_short_o", bus.short_o, 32'd0);
        check_vec("reset_dout", bus.dout, '0);
        rstn = 1'b1;
        idle(2);

        // Full frame, no in_last.
        sc = strobe_cnt;
        for (int b = 0; b < BEATS; b++) drive(splat(8'd3), splat(8'hFE), 1'b0);
        idle(3);
        check("full_strobes", strobe_cnt - sc, 32'd1);
        check("full_latency", last_strobe_cyc - last_acc_cyc, 32'd1);
        check("full_p0", last_dout[15:0], 32'hFFFA);
        check("full_p143", last_dout[DOUT_W-1 -: 16], 32'hFFFA);
        check("full_short", last_short, 32'd0);

        // Back-to-back frames with in_vld held through ISSUE.
        sc = strobe_cnt;
        frame_pat(1, 2, 0);
        for (int b = 0; b < BEATS; b++) drive(splat(8'hFB), splat(8'h07), 1'b0);
        idle(3);
        check("b2b_strobes", strobe_cnt - sc, 32'd2);
        check("b2b_spacing", last_strobe_cyc - prev_strobe_cyc, 32'd10);
        check("b2b_p100", last_dout[16*100 +: 16], 32'hFFDD);

        // Early close after 4 beats.
        for (int b = 0; b < 4; b++) drive(splat(8'd127), splat(8'd127), b == 3);
        idle(3);
        check("early_short", last_short, 32'd1);
        check("early_p0", last_dout[15:0], 32'h3F01);
        check("early_p63", last_dout[16*63 +: 16], 32'h3F01);
        check("early_p64", last_dout[16*64 +: 16], 32'h0000);
        check("early_p143", last_dout[16*143 +: 16], 32'h0000);
        frame_pat(3, 4, 0);
        idle(3);
        check("early_then_full_short", last_short, 32'd0);

        // Corner products in lanes 0..2 of beat 0.
        a = pat_vec(5, 0);
        w = pat_vec(6, 0);
        a[7:0]   = 8'h80; w[7:0]   = 8'h80;
        a[15:8]  = 8'h80; w[15:8]  = 8'h7F;
        a[23:16] = 8'h00; w[23:16] = 8'h37;
        drive(a, w, 1'b0);
        for (int b = 1; b < BEATS; b++) drive(pat_vec(5, b), pat_vec(6, b), 1'b0);
        idle(3);
        check("corner_p0", last_dout[15:0], 32'h4000);
        check("corner_p1", last_dout[31:16], 32'hC080);
        check("corner_p2", last_dout[47:32], 32'h0000);

        // Same operand sequence without and with handshake gaps.
        sc = strobe_cnt;
        frame_pat(7, 8, 0);
        idle(3);
        frame_pat(7, 8, 3);
        idle(3);
        check("gap_strobes", strobe_cnt - sc, 32'd2);
        check("gap_latency", last_strobe_cyc - last_acc_cyc, 32'd1);

        // Reset after 5 beats, with short_o set by a preceding early close.
        drive(splat(8'd1), splat(8'd1), 1'b0);
        drive(splat(8'd1), splat(8'd1), 1'b1);
        idle(3);
        check("pre_reset_short", last_short, 32'd1);
        for (int b = 0; b < 5; b++) drive(pat_vec(9, b), pat_vec(10, b), 1'b0);
        sc   = strobe_cnt;
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_out_vld", bus.out_vld, 32'd0);
        check("midrst_short_o", bus.short_o, 32'd0);
        check_vec("midrst_dout", bus.dout, '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        idle(4);
        check("no_spurious_strobe", strobe_cnt - sc, 32'd0);
        frame_pat(9, 10, 0);
        idle(3);
        check("post_rst_strobes", strobe_cnt - sc, 32'd1);
        check("post_rst_latency", last_strobe_cyc - last_acc_cyc, 32'd1);
        check("post_rst_p0", last_dout[15:0], 32'h224A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
